// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter with a registered single-entry output stage.
// One requester slice is accepted per handshake and held until the consumer takes it.
module rr_mux_arbiter #(
  parameter int unsigned N     = 8,
  parameter int unsigned width = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*width-1:0]   req_data,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  output logic [width-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_sel,
  input  logic                 out_ready
);

  localparam int unsigned SelW = $clog2(N);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [SelW-1:0] ptr_q, ptr_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [width-1:0] data_q, data_d;

  logic [SelW-1:0] gnt;
  logic            any_req;
  logic            can_accept;
  logic            accept;

  // Scan from the priority pointer upward, wrapping at N; the first hit wins.
  always_comb begin
    gnt     = '0;
    any_req = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (int'(ptr_q) + k) % N;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        gnt     = SelW'(idx);
      end
    end
  end

  assign can_accept = (state_q == StIdle) || out_ready;
  assign accept     = rst_n && can_accept && any_req;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[gnt] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (accept) begin
      state_d = StBusy;
      sel_d   = gnt;
      data_d  = req_data[width*gnt +: width];
      ptr_d   = (gnt == SelW'(N - 1)) ? '0 : gnt + 1'b1;
    end else if (state_q == StBusy && out_ready) begin
      // Drained with nothing to replace it; data and sel keep their last value.
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == StBusy);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a per-cycle reference model checked on the falling edge
// plus literal expectations for the reset, grant order, stall, wrap and mid-transfer reset cases.
module tb_rr_mux_arbiter;

  localparam int N = 8;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int  m_ptr   = 0;
  bit  m_valid = 0;
  int  m_data  = 0;
  int  m_sel   = 0;
  bit  started = 0;

  rr_mux_arbiter #(.N(N), .width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner of the round-robin scan, or -1 if no one is requesting.
  function automatic int model_gnt();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g;
    logic [N-1:0] r;
    r = '0;
    g = model_gnt();
    if (rst_n && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    int g;
    g = model_gnt();
    started <= 1'b1;
    if (!rst_n) begin
      m_valid <= 0; m_data <= 0; m_sel <= 0; m_ptr <= 0;
    end else if ((!m_valid || out_ready) && g >= 0) begin
      m_valid <= 1;
      m_sel   <= g;
      m_data  <= int'((req_data >> (W * g)) & 7);
      m_ptr   <= (g + 1) % N;
    end else if (out_ready) begin
      m_valid <= 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model req_ready", 32'(req_ready), 32'(model_ready()));
      chk("model out_valid", 32'(out_valid), 32'(m_valid));
      chk("model out_sel",   32'(out_sel),   32'(m_sel));
      chk("model out_data",  32'(out_data),  32'(m_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 8'hFF;
    req_data  = '0;
    out_ready = 1'b1;

    // 1: reset holds everything quiet
    step();
    chk("rst req_ready", 32'(req_ready), 0);
    step();
    chk("rst req_ready2", 32'(req_ready), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_sel",   32'(out_sel), 0);
    chk("rst out_data",  32'(out_data), 0);

    // 2: single requester
    rst_n     = 1'b1;
    req_valid = 8'h04;
    req_data  = 24'(3'b101) << 6;
    #1;
    chk("t2 req_ready", 32'(req_ready), 32'h04);
    step();
    chk("t2 out_valid", 32'(out_valid), 1);
    chk("t2 out_data",  32'(out_data), 5);
    chk("t2 out_sel",   32'(out_sel), 2);
    req_valid = 8'h00;
    step();
    chk("t2 drain", 32'(out_valid), 0);
    chk("t2 data kept", 32'(out_data), 5);
    step();  // idle cycle: ptr must not move

    // Brief reset to return ptr to 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // 3: all requesting, slice i = i
    req_valid = 8'hFF;
    for (int i = 0; i < N; i++) req_data[W*i +: W] = W'(i);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t3 out_sel",  32'(out_sel),  32'(k % N));
      chk("t3 out_data", 32'(out_data), 32'(k % N));
    end

    // 4: stall with sel=3 pending
    out_ready = 1'b0;
    #1;
    chk("t4 req_ready", 32'(req_ready), 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4 hold sel",  32'(out_sel), 3);
      chk("t4 hold data", 32'(out_data), 3);
      chk("t4 hold vld",  32'(out_valid), 1);
      chk("t4 hold rdy",  32'(req_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("t4 resume rdy", 32'(req_ready), 32'h10);
    step();
    chk("t4 resume sel", 32'(out_sel), 4);

    // 5: wrap from ptr=7
    step();
    chk("t5 sel5", 32'(out_sel), 5);
    step();
    chk("t5 sel6", 32'(out_sel), 6);
    req_valid = 8'h81;
    #1;
    chk("t5 rdy7", 32'(req_ready), 32'h80);
    step();
    chk("t5 sel7", 32'(out_sel), 7);
    chk("t5 rdy0", 32'(req_ready), 32'h01);
    step();
    chk("t5 sel0", 32'(out_sel), 0);
    req_valid = 8'hFF;
    #1;
    chk("t5 ptr1", 32'(req_ready), 32'h02);

    // 6: reset while a transfer is pending
    out_ready = 1'b0;
    #1;
    chk("t6 stall rdy", 32'(req_ready), 0);
    step();
    chk("t6 pending", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6 rst rdy", 32'(req_ready), 0);
    step();
    chk("t6 rst vld", 32'(out_valid), 0);
    chk("t6 rst sel", 32'(out_sel), 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t6 first rdy", 32'(req_ready), 32'h01);
    step();
    chk("t6 first sel", 32'(out_sel), 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
